// File: rtl/ex_lat_pkg.sv
// Shared definitions for the EX-stage latency tracker: op class codes,
// fixed per-class latencies and the countdown width.
package ex_lat_pkg;

  localparam logic [1:0] EX_CLS_0   = 2'b00;
  localparam logic [1:0] EX_CLS_1   = 2'b01;
  localparam logic [1:0] EX_CLS_2   = 2'b10;
  localparam logic [1:0] EX_CLS_ILL = 2'b11;

  localparam int EX_LAT0  = 12;
  localparam int EX_LAT1  = 20;
  localparam int EX_LAT2  = 27;
  localparam int EX_CNT_W = 5;

  // Latency ROM: cycles from acceptance until the op becomes completable.
  // The illegal class completes after one cycle so it can report its error.
  function automatic int ex_lat_cycles(logic [1:0] cls, int lat0, int lat1, int lat2);
    int l;
    case (cls)
      EX_CLS_0: l = lat0;
      EX_CLS_1: l = lat1;
      EX_CLS_2: l = lat2;
      default:  l = 1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/ex_latency_slot.sv
// One in-flight op: valid/err/tag plus a saturating countdown. The slot is
// completable while valid with a zero count and holds there until freed.
module ex_latency_slot
  import ex_lat_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int CNT_W = EX_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_cnt_i,
  input  logic [TAG_W-1:0] load_tag_i,
  input  logic             load_err_i,
  input  logic             free_i,
  output logic             valid_o,
  output logic             done_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             err_o
);

  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next state: decrement, free, load, then flush as the final override.
  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    if (valid_q && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);
    if (free_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      err_d   = load_err_i;
      tag_d   = load_tag_i;
      cnt_d   = load_cnt_i;
    end
    if (flush_i) valid_d = 1'b0;
  end

  // Slot state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o = valid_q;
  assign done_o  = valid_q && (cnt_q == '0);
  assign tag_o   = tag_q;
  assign err_o   = err_q;

endmodule

// File: rtl/ex_latency_tracker.sv
// EX-stage latency tracker: places issued ops in the lowest free slot, counts
// down each op's class latency and presents completions lowest-slot-first.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. ISSUE_READY and DONE_VALID/TAG/ERR are functions of registered state
// only, so neither ISSUE_* nor DONE_READY reaches an output combinationally;
// a slot freed by a pop becomes reusable only from the following cycle.
module ex_latency_tracker
  import ex_lat_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int TAG_W = 5,
  parameter int LAT0  = EX_LAT0,
  parameter int LAT1  = EX_LAT1,
  parameter int LAT2  = EX_LAT2,
  parameter int CNT_W = EX_CNT_W
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     FLUSH,
  input  logic                     ISSUE_VALID,
  output logic                     ISSUE_READY,
  input  logic [1:0]               ISSUE_SELECT,
  input  logic [TAG_W-1:0]         ISSUE_TAG,
  output logic                     DONE_VALID,
  input  logic                     DONE_READY,
  output logic [TAG_W-1:0]         DONE_TAG,
  output logic                     DONE_ERR,
  output logic [$clog2(SLOTS):0]   OUTSTANDING
);

  localparam int OUT_W = $clog2(SLOTS) + 1;

  logic [SLOTS-1:0] slot_valid;
  logic [SLOTS-1:0] slot_done;
  logic [SLOTS-1:0] slot_err;
  logic [TAG_W-1:0] slot_tag [SLOTS];
  logic [SLOTS-1:0] load_vec;
  logic [SLOTS-1:0] pop_vec;
  logic [CNT_W-1:0] load_cnt;
  logic             load_err;
  logic             issue_fire;
  logic             pop_fire;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;

  assign ISSUE_READY = ~&slot_valid;
  assign DONE_VALID  = |slot_done;
  assign issue_fire  = ISSUE_VALID & ISSUE_READY;
  assign pop_fire    = DONE_VALID & DONE_READY;
  assign load_cnt    = CNT_W'(ex_lat_cycles(ISSUE_SELECT, LAT0, LAT1, LAT2) - 1);
  assign load_err    = (ISSUE_SELECT == EX_CLS_ILL);

  // Free-slot priority: the accepted op goes to the lowest-index empty slot.
  always_comb begin
    logic found;
    found    = 1'b0;
    load_vec = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!slot_valid[i] && !found) begin
        found       = 1'b1;
        load_vec[i] = issue_fire;
      end
    end
  end

  // Completion priority: present and pop the lowest-index completable slot.
  always_comb begin
    logic found;
    found    = 1'b0;
    pop_vec  = '0;
    DONE_TAG = '0;
    DONE_ERR = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_done[i] && !found) begin
        found      = 1'b1;
        DONE_TAG   = slot_tag[i];
        DONE_ERR   = slot_err[i];
        pop_vec[i] = DONE_READY;
      end
    end
  end

  // Occupancy: +1 on issue, -1 on pop, cleared by flush.
  always_comb begin
    outstanding_d = outstanding_q + OUT_W'(issue_fire) - OUT_W'(pop_fire);
    if (FLUSH) outstanding_d = '0;
  end

  // Occupancy register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) outstanding_q <= '0;
    else        outstanding_q <= outstanding_d;
  end

  assign OUTSTANDING = outstanding_q;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    ex_latency_slot #(
      .TAG_W (TAG_W),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .flush_i    (FLUSH),
      .load_i     (load_vec[i]),
      .load_cnt_i (load_cnt),
      .load_tag_i (ISSUE_TAG),
      .load_err_i (load_err),
      .free_i     (pop_vec[i]),
      .valid_o    (slot_valid[i]),
      .done_o     (slot_done[i]),
      .tag_o      (slot_tag[i]),
      .err_o      (slot_err[i])
    );
  end

endmodule

// File: doc/ex_latency_tracker.md
Name: ex_latency_tracker

Overview:
- Consumer side of the EX-stage latency table: accepts multi-cycle EX operations tagged with a 2-bit op class, loads that class's fixed latency (12/20/27 cycles), counts it down, and presents completions to writeback on a valid/ready handshake.
- Sits beside the multi-cycle EX units.
- ISSUE_READY drives the ID/EX stall.
- DONE_* feeds the writeback arbiter.

Parameters:
- SLOTS, 4, number of operations that may be in flight simultaneously (2..8).
- TAG_W, 5, width of the tag carried per op (destination register index).
- LAT0, 12, latency in cycles for op class 2'b00.
- LAT1, 20, latency in cycles for op class 2'b01.
- LAT2, 27, latency in cycles for op class 2'b10.
- CNT_W, 5, countdown width; must satisfy 2^CNT_W > max(LAT0, LAT1, LAT2).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous kill of all in-flight ops (pipeline flush).
- ISSUE_VALID  in  1  op offered.
- ISSUE_READY  out  1  a free slot exists.
- ISSUE_SELECT  in  2  op class.
- ISSUE_TAG  in  TAG_W  tag returned on completion.
- DONE_VALID  out  1  a completed op is presented.
- DONE_READY  in  1  writeback accepts the completion.
- DONE_TAG  out  TAG_W  tag of the presented completion.
- DONE_ERR  out  1  presented op used illegal class 2'b11.
- OUTSTANDING  out  $clog2(SLOTS)+1  count of occupied slots.

Behaviour:
- **Reset (RST_N low, async):**
  - All slots are invalidated; counters and tags are cleared.
  - ISSUE_READY=1, DONE_VALID=0, DONE_TAG=0, DONE_ERR=0, OUTSTANDING=0.
- **Latency:**
  - L = LAT0/LAT1/LAT2 for class 00/01/10; class 11 gives L=1 and sets the slot's err bit.
  - If an issue is accepted at the edge ending cycle t, the op is completable from cycle t+L.
  - Implementation: the counter loads L-1 at acceptance and decrements on each edge while nonzero.
  - A slot is completable when valid and its counter is 0; it holds in that state until popped.
- **Issue:**
  - Handshake is ISSUE_VALID & ISSUE_READY.
  - The accepted op goes to the lowest-index free slot.
  - ISSUE_READY = (any slot free), computed from registered state only.
  - A slot freed by a pop in the same cycle is NOT reusable that cycle. Consequently, when full with a pop pending, ISSUE_READY stays 0 until the next cycle.
- **Completion:**
  - DONE_VALID = any completable slot.
  - DONE_TAG and DONE_ERR come from the completable slot with the lowest index (fixed priority).
  - On DONE_VALID & DONE_READY the selected slot is freed at the edge.
  - Outputs are stable while DONE_VALID=1 and DONE_READY=0, unless a lower-index slot becomes completable; the priority switch is allowed.
  - There is no combinational path from ISSUE_* or DONE_READY to any output.
- **Counting:**
  - OUTSTANDING updates as +1 on issue and −1 on pop; simultaneous issue and pop leave it unchanged.
  - It never exceeds SLOTS.
- **FLUSH:**
  - Takes effect at the edge; all slots are invalidated.
  - It overrides a same-cycle issue (the op is dropped even though it was handshaken) and a same-cycle pop.
  - DONE_VALID is 0 in the next cycle.
- **Reset mid-operation:** all ops are lost immediately and there is no completion.
- **Counters:** saturate at 0 and never wrap.
- **Equal latencies:** two ops with equal L issued on consecutive cycles complete in issue order only if slot order matches. The ordering guarantee is lowest-index-first, not age.

Decomposition:
- Shared package ex_lat_pkg:
  - op class codes EX_CLS_0..EX_CLS_ILL (2'b00..2'b11);
  - latency constants 12/20/27, shared with the latency ROM so both stay consistent;
  - CNT_W.
- One sub-module, ex_latency_slot, holds:
  - the per-slot valid, err, tag and counter;
  - load, decrement and free controls.
- The top level does free-slot and completion priority encoding.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles, then release → ISSUE_READY=1, DONE_VALID=0, OUTSTANDING=0.
- Basic latency:
  - Issue class 00, tag 7, in cycle 10 → DONE_VALID first high in cycle 22 with DONE_TAG=7.
  - Repeat with class 01 → cycle 30; class 10 → cycle 37.
  - DONE_READY=1 pops immediately.
- Full and backpressure:
  - With DONE_READY=0, issue 4 class-11 ops with tags 1..4 → ISSUE_READY=0 after the 4th, OUTSTANDING=4, DONE_TAG=1 with DONE_ERR=1.
  - Pop one → ISSUE_READY returns 1 the cycle after the pop, not the same cycle.
- Out-of-order completion:
  - Issue class 10 (tag 3) at cycle 0, then class 00 (tag 9) at cycle 1.
  - → tag 9 completes at cycle 13, tag 3 at cycle 27.
- Stall hold:
  - Class 00 op completable, DONE_READY=0 for 5 cycles → DONE_VALID and DONE_TAG stay constant and OUTSTANDING is unchanged.
  - Then pop → OUTSTANDING decrements by 1.
- Flush:
  - With 3 ops in flight, assert FLUSH in the same cycle as a new issue and a pop → next cycle OUTSTANDING=0, DONE_VALID=0, ISSUE_READY=1.
  - The dropped op never appears.
